// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave backed by a word-organised on-chip SRAM.
//
// The slave accepts an address phase when HSELx & HREADYIN & HTRANS[1] are all high at a
// rising edge. It then runs a data phase of WAIT_STATES+1 cycles and supports byte, halfword
// and word accesses on little-endian byte lanes. An illegal transfer gets a two-cycle ERROR
// response and does not touch the array.
//
// Ports:
//   HCLK      in   bus clock, rising edge
//   HRESETn   in   asynchronous active-low reset
//   HSELx     in   slave select from the address decoder
//   HADDR     in   byte address (address phase)
//   HWRITE    in   1 = write, 0 = read
//   HTRANS    in   IDLE/BUSY/NONSEQ/SEQ
//   HSIZE     in   000 byte, 001 halfword, 010 word
//   HBURST    in   burst type, ignored (the master supplies every beat address)
//   HWDATA    in   write data (data phase)
//   HREADYIN  in   global bus HREADY (previous transfer complete)
//   HREADY    out  data phase complete
//   HRESP     out  OKAY=00, ERROR=01
//   HRDATA    out  read data, full word, zero outside read data phases

module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW+1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              hready_q, hready_d;
    logic [1:0]        hresp_q, hresp_d;

    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              illegal;
    logic              phase_done;
    logic [ADDR_W-3:0] idx_in;
    logic [IdxW-1:0]   mem_idx;
    logic [3:0]        be;
    logic              mem_we;

    // Bus inputs that carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:ADDR_W], HTRANS[0]};

    assign accept = HSELx & HREADYIN & HTRANS[1];
    assign idx_in = HADDR[ADDR_W-1:2];

    assign illegal = (HSIZE > 3'b010)
                   || ((HSIZE == 3'b001) && HADDR[0])
                   || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                   || (32'(idx_in) >= DEPTH);

    // A new address phase can only start in a cycle where this slave drives HREADY high.
    assign phase_done = (state_q == StIdle)
                      || ((state_q == StData) && (cnt_q == '0))
                      || (state_q == StErr2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        case (state_q)
            StData: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: ;
        endcase

        if (phase_done) begin
            state_d = StIdle;
            if (accept) begin
                addr_d  = HADDR[IdxW+1:0];
                write_d = HWRITE;
                size_d  = HSIZE[1:0];
                if (illegal) begin
                    state_d = StErr1;
                end else begin
                    state_d = StData;
                    cnt_d   = CntW'(WAIT_STATES);
                end
            end
        end

        // Outputs are registered: decode them from the state being entered.
        hready_d = !(((state_d == StData) && (cnt_d != '0)) || (state_d == StErr1));
        hresp_d  = ((state_d == StErr1) || (state_d == StErr2)) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    assign mem_idx = addr_q[IdxW+1:2];

    // Little-endian lane enables; only legal (aligned) sizes ever reach StData.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // The write commits at the edge that closes the data phase. A reset drops state_q to
    // StIdle at once, which discards a write that is still pending.
    assign mem_we = (state_q == StData) && (cnt_q == '0) && write_q;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = ((state_q == StData) && !write_q) ? mem_q[mem_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave. It uses three instances with WAIT_STATES 0, 2 and 3 on one
// shared bus. A byte-level reference model is advanced once per cycle at the falling edge,
// and directed transfers carry hand-computed expectations.
module tb_ahb_sram_slave;

    localparam logic [1:0] TrIdle = 2'b00;
    localparam logic [1:0] TrBusy = 2'b01;
    localparam logic [1:0] TrNseq = 2'b10;
    localparam logic [1:0] TrSeq  = 2'b11;
    localparam logic [2:0] SzB    = 3'b000;
    localparam logic [2:0] SzH    = 3'b001;
    localparam logic [2:0] SzW    = 3'b010;

    logic        HCLK;
    logic        HRESETn;
    logic [2:0]  sel_v;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready [3];
    logic [1:0]  hresp  [3];
    logic [31:0] hrdata [3];
    logic        hreadyin;

    assign hreadyin = hready[0] & hready[1] & hready[2];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave #(
            .DEPTH      (1024),
            .ADDR_W     (13),
            .WAIT_STATES((g == 0) ? 0 : g + 1)
        ) u_dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .HSELx   (sel_v[g]),
            .HADDR   (haddr),
            .HWRITE  (hwrite),
            .HTRANS  (htrans),
            .HSIZE   (hsize),
            .HBURST  (hburst),
            .HWDATA  (hwdata),
            .HREADYIN(hreadyin),
            .HREADY  (hready[g]),
            .HRESP   (hresp[g]),
            .HRDATA  (hrdata[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mm [logic [14:0]];   // key {dut, byte address}
    bit          m_act   [3];
    bit          m_err   [3];
    bit          m_wr    [3];
    int          m_stage [3];
    int          m_left  [3];
    logic [31:0] m_addr  [3];
    logic [2:0]  m_size  [3];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] sz);
        return (sz > 3'd2) || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00))
               || (a[12:2] >= 11'd1024);
    endfunction

    function automatic logic [31:0] m_word(input int d, input logic [31:0] a, output bit known);
        logic [31:0] w;
        logic [12:0] b;
        w     = '0;
        known = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = {a[12:2], 2'b00} + 13'(k);
            if (mm.exists({2'(d), b})) w[8*k +: 8] = mm[{2'(d), b}];
            else known = 1'b0;
        end
        return w;
    endfunction

    initial begin : compare
        bit          e_rdy   [3];
        logic [1:0]  e_resp  [3];
        logic [31:0] e_data  [3];
        bit          e_known [3];
        bit          g_rdy;
        bit          dn;
        logic [12:0] b;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                for (int d = 0; d < 3; d++) m_act[d] = 1'b0;
            end
            for (int d = 0; d < 3; d++) begin
                e_rdy[d]   = 1'b1;
                e_resp[d]  = 2'b00;
                e_data[d]  = 32'h0;
                e_known[d] = 1'b1;
                if (m_act[d] && m_err[d]) begin
                    e_rdy[d]  = (m_stage[d] == 2);
                    e_resp[d] = 2'b01;
                end else if (m_act[d]) begin
                    e_rdy[d] = (m_left[d] == 0);
                    if (!m_wr[d]) e_data[d] = m_word(d, m_addr[d], e_known[d]);
                end
                chk($sformatf("cyc_ready_resp_u%0d", d), {29'b0, hready[d], hresp[d]},
                    {29'b0, e_rdy[d], e_resp[d]});
                if (e_known[d]) chk($sformatf("cyc_rdata_u%0d", d), hrdata[d], e_data[d]);
            end
            g_rdy = e_rdy[0] & e_rdy[1] & e_rdy[2];
            if (HRESETn) begin
                for (int d = 0; d < 3; d++) begin
                    dn = !m_act[d] || (!m_err[d] && m_left[d] == 0)
                         || (m_err[d] && m_stage[d] == 2);
                    if (!dn) begin
                        if (m_err[d]) m_stage[d] = 2;
                        else m_left[d] = m_left[d] - 1;
                    end else begin
                        if (m_act[d] && !m_err[d] && m_wr[d]) begin
                            for (int k = 0; k < (1 << m_size[d]); k++) begin
                                b = m_addr[d][12:0] + 13'(k);
                                mm[{2'(d), b}] = hwdata[8*b[1:0] +: 8];
                            end
                        end
                        m_act[d] = 1'b0;
                        if (g_rdy && sel_v[d] && htrans[1]) begin
                            m_act[d]   = 1'b1;
                            m_err[d]   = is_illegal(haddr, hsize);
                            m_stage[d] = 1;
                            m_left[d]  = ws_of(d);
                            m_wr[d]    = hwrite;
                            m_addr[d]  = haddr;
                            m_size[d]  = hsize;
                        end
                    end
                end
            end
        end
    end

    // ---------------- bus master ----------------
    logic [31:0] pend_wd = 32'h0;
    int          last_d  = 0;

    // Drives one address phase (with the previous beat's write data) and returns the
    // previous beat's data-phase response: HRDATA/HRESP at its completing cycle, wait count.
    task automatic beat(input int d, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [1:0] rs, output int waits);
        int pd;
        pd     = last_d;
        last_d = d;
        sel_v  = 3'(1 << d);
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hwdata = pend_wd;
        pend_wd = wd;
        waits  = 0;
        @(negedge HCLK);
        while (!hreadyin && waits < 64) begin
            waits++;
            @(negedge HCLK);
        end
        chk("bus_hready_timeout", 32'(hreadyin), 32'h1);
        rd = hrdata[pd];
        rs = hresp[pd];
        @(posedge HCLK);
        #1;
    endtask

    initial begin : main
        logic [31:0] r;
        logic [1:0]  s;
        int          w;
        int          tot;
        logic [31:0] ea [4];
        logic [2:0]  es [4];

        HRESETn = 1'b1;
        sel_v   = 3'b000;
        haddr   = 32'h0;
        hwrite  = 1'b0;
        htrans  = TrIdle;
        hsize   = SzB;
        hburst  = 3'b000;
        hwdata  = 32'h0;
        #2 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_hready", 32'(hready[0]), 32'h1);
        chk("reset_hresp", 32'(hresp[2]), 32'h0);
        chk("reset_hrdata", hrdata[1], 32'h0);
        HRESETn = 1'b1;

        // Zero-wait word write then read.
        beat(0, TrNseq, 1'b1, 32'h10, SzW, 32'hDEADBEEF, r, s, w);
        beat(0, TrNseq, 1'b0, 32'h10, SzW, 32'h0, r, s, w);
        chk("ws0_write_waits", 32'(w), 32'd0);
        chk("ws0_write_resp", 32'(s), 32'd0);
        beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("ws0_read_data", r, 32'hDEADBEEF);
        chk("ws0_read_waits", 32'(w), 32'd0);

        // Byte and halfword lanes over a zeroed word.
        beat(0, TrNseq, 1'b1, 32'h10, SzW, 32'h0000_0000, r, s, w);
        beat(0, TrNseq, 1'b1, 32'h11, SzB, 32'h0000_AA00, r, s, w);
        beat(0, TrNseq, 1'b1, 32'h12, SzH, 32'h1234_0000, r, s, w);
        beat(0, TrNseq, 1'b0, 32'h10, SzW, 32'h0, r, s, w);
        beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("lanes_read", r, 32'h1234_AA00);
        beat(0, TrNseq, 1'b1, 32'h0, SzW, 32'h1122_3344, r, s, w);
        beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);

        // Illegal transfers: two-cycle ERROR, no array access.
        ea = '{32'h13, 32'h1000, 32'h11, 32'h14};
        es = '{SzW, SzW, SzH, 3'b011};
        for (int i = 0; i < 4; i++) begin
            beat(0, TrNseq, 1'b1, ea[i], es[i], 32'hFFFF_FFFF, r, s, w);
            beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
            chk($sformatf("err%0d_waits", i), 32'(w), 32'd1);
            chk($sformatf("err%0d_resp", i), 32'(s), 32'd1);
        end
        beat(0, TrNseq, 1'b0, 32'h10, SzW, 32'h0, r, s, w);
        beat(0, TrNseq, 1'b0, 32'h0, SzW, 32'h0, r, s, w);
        chk("err_target_unchanged", r, 32'h1234_AA00);
        beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("err_alias_unchanged", r, 32'h1122_3344);

        // Pipelined write then read, then BUSY/IDLE with select high.
        beat(0, TrNseq, 1'b1, 32'h20, SzW, 32'h0000_0055, r, s, w);
        beat(0, TrNseq, 1'b0, 32'h20, SzW, 32'h0, r, s, w);
        beat(0, TrBusy, 1'b1, 32'h20, SzW, 32'hFFFF_FFFF, r, s, w);
        chk("pipe_read_data", r, 32'h0000_0055);
        beat(0, TrIdle, 1'b1, 32'h20, SzW, 32'hFFFF_FFFF, r, s, w);
        chk("busy_waits", 32'(w), 32'd0);
        chk("busy_resp", 32'(s), 32'd0);
        beat(0, TrNseq, 1'b0, 32'h20, SzW, 32'h0, r, s, w);
        beat(0, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("busy_no_access", r, 32'h0000_0055);

        // Two wait states.
        beat(1, TrNseq, 1'b1, 32'h100, SzW, 32'hA5A5_0001, r, s, w);
        beat(1, TrNseq, 1'b0, 32'h100, SzW, 32'h0, r, s, w);
        chk("ws2_write_waits", 32'(w), 32'd2);
        beat(1, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("ws2_read_waits", 32'(w), 32'd2);
        chk("ws2_read_data", r, 32'hA5A5_0001);

        hburst = 3'b011;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            beat(1, (i == 0) ? TrNseq : TrSeq, 1'b1, 32'h200 + 32'(4 * i), SzW,
                 32'h1000 + 32'(i), r, s, w);
            if (i > 0) tot += w + 1;
        end
        beat(1, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        tot += w + 1;
        chk("ws2_burst_cycles", 32'(tot), 32'd12);
        for (int i = 0; i < 4; i++) begin
            beat(1, (i == 0) ? TrNseq : TrSeq, 1'b0, 32'h200 + 32'(4 * i), SzW, 32'h0, r, s, w);
            if (i > 0) chk($sformatf("ws2_burst_rd%0d", i - 1), r, 32'h1000 + 32'(i - 1));
        end
        beat(1, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("ws2_burst_rd3", r, 32'h1003);
        hburst = 3'b000;

        // Three wait states, reset in the second wait cycle of a write.
        beat(2, TrNseq, 1'b1, 32'h40, SzW, 32'hCAFE_F00D, r, s, w);
        beat(2, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("ws3_write_waits", 32'(w), 32'd3);
        beat(2, TrNseq, 1'b1, 32'h40, SzW, 32'h0BAD_BEEF, r, s, w);
        sel_v  = 3'b100;
        htrans = TrIdle;
        hwdata = pend_wd;
        last_d = 2;
        chk("ws3_wait1_hready", 32'(hready[2]), 32'h0);
        @(posedge HCLK);
        #1;
        chk("ws3_wait2_hready", 32'(hready[2]), 32'h0);
        HRESETn = 1'b0;
        #1;
        chk("ws3_reset_hready", 32'(hready[2]), 32'h1);
        chk("ws3_reset_hresp", 32'(hresp[2]), 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        beat(2, TrNseq, 1'b0, 32'h40, SzW, 32'h0, r, s, w);
        beat(2, TrIdle, 1'b0, 32'h0, SzB, 32'h0, r, s, w);
        chk("ws3_write_discarded", r, 32'hCAFE_F00D);

        repeat (2) @(posedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
